// File: rtl/mem_arbiter_if.sv
// Request/response bundle for the two-requester memory arbiter: imem and dmem
// requester ports plus the shared memory port. master = arbiter side.
interface mem_arbiter_if;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;

  logic        dmemreq_val;
  logic        dmemreq_rdy;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;

  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;

  modport master (
    input  imemreq_val, imemreq_addr,
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    input  memreq_rdy, memresp_val, memresp_data,
    output imemreq_rdy, imemresp_val, imemresp_data,
    output dmemreq_rdy, dmemresp_val, dmemresp_data,
    output memreq_val, memreq_type, memreq_addr, memreq_wdata
  );

  modport slave (
    output imemreq_val, imemreq_addr,
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    output memreq_rdy, memresp_val, memresp_data,
    input  imemreq_rdy, imemresp_val, imemresp_data,
    input  dmemreq_rdy, dmemresp_val, dmemresp_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between imem and dmem: dmem priority with an
// anti-starvation override, in-order owner-tag FIFO routes responses back.
module mem_arbiter #(
  parameter int unsigned p_depth  = 2,
  parameter int unsigned p_starve = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          err
);

  localparam int unsigned CW = $clog2(p_depth + 1);
  localparam int unsigned SW = $clog2(p_starve + 1);

  logic [p_depth-1:0] tags_q, tags_d;
  logic [CW-1:0]      count_q, count_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               err_q, err_d;

  logic        issue_ok;
  logic        grant_imem, grant_dmem;
  logic        push, pop, stray;
  int unsigned wr_idx;

  always_comb begin
    issue_ok   = !rst && (count_q < CW'(p_depth));
    grant_imem = 1'b0;
    grant_dmem = 1'b0;
    if (issue_ok) begin
      if ((starve_q == SW'(p_starve)) && bus.imemreq_val) grant_imem = 1'b1;
      else if (bus.dmemreq_val)                              grant_dmem = 1'b1;
      else if (bus.imemreq_val)                              grant_imem = 1'b1;
    end

    bus.memreq_val   = grant_imem | grant_dmem;
    bus.memreq_type  = grant_dmem & bus.dmemreq_type;
    bus.memreq_addr  = grant_dmem ? bus.dmemreq_addr : bus.imemreq_addr;
    bus.memreq_wdata = grant_dmem ? bus.dmemreq_wdata : '0;
    bus.imemreq_rdy  = grant_imem & bus.memreq_rdy;
    bus.dmemreq_rdy  = grant_dmem & bus.memreq_rdy;

    push  = bus.memreq_val & bus.memreq_rdy;
    pop   = !rst && bus.memresp_val && (count_q != '0);
    stray = !rst && bus.memresp_val && (count_q == '0);

    bus.imemresp_val  = pop & ~tags_q[0];
    bus.dmemresp_val  = pop &  tags_q[0];
    bus.imemresp_data = bus.memresp_data;
    bus.dmemresp_data = bus.memresp_data;

    // Shift-register FIFO with head at bit 0; on a simultaneous pop the
    // write slot moves down by one so ordering is kept.
    tags_d = pop ? (tags_q >> 1) : tags_q;
    wr_idx = 32'(count_q) - (pop ? 32'd1 : 32'd0);
    if (push) begin
      tags_d = (tags_d & ~(p_depth'(1) << wr_idx)) |
               (p_depth'(grant_dmem) << wr_idx);
    end

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    starve_d = starve_q;
    if (!bus.imemreq_val || (push && grant_imem)) begin
      starve_d = '0;
    end else if (push && grant_dmem && (starve_q != SW'(p_starve))) begin
      starve_d = starve_q + SW'(1);
    end

    err_d = err_q | stray;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tags_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      tags_q   <= tags_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected responses are queued by the
// stimulus and checked by an independent response monitor.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic err;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.p_depth(2), .p_starve(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  typedef struct {
    logic        owner;  // 1 = dmem, 0 = imem
    logic [31:0] data;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1 && (bus.imemresp_val === 1'b1 || bus.dmemresp_val === 1'b1)) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", {30'd0, bus.imemresp_val, bus.dmemresp_val}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_owner", {30'd0, bus.imemresp_val, bus.dmemresp_val},
              mon_e.owner ? 32'd1 : 32'd2);
        if (mon_e.chk)
          check("resp_data", mon_e.owner ? bus.dmemresp_data : bus.imemresp_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mresp(input logic owner, input logic [31:0] data, input logic chk);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    e.chk   = chk;
    bus.memresp_val  = 1'b1;
    bus.memresp_data = data;
    sb.push_back(e);
  endtask

  logic prev_owner;
  logic exp_i;

  initial begin
    rst               = 1'b1;
    bus.imemreq_val   = 1'b1;
    bus.imemreq_addr  = 32'h0;
    bus.dmemreq_val   = 1'b1;
    bus.dmemreq_type  = 1'b0;
    bus.dmemreq_addr  = 32'h0;
    bus.dmemreq_wdata = 32'h0;
    bus.memreq_rdy    = 1'b1;
    bus.memresp_val   = 1'b1;
    bus.memresp_data  = 32'h0;

    // Reset: everything forced low, stray responses ignored
    @(negedge clk);
    check("rst_memreq_val", bus.memreq_val, 0);
    check("rst_imemreq_rdy", bus.imemreq_rdy, 0);
    check("rst_dmemreq_rdy", bus.dmemreq_rdy, 0);
    check("rst_imemresp_val", bus.imemresp_val, 0);
    check("rst_dmemresp_val", bus.dmemresp_val, 0);
    step();
    step();
    rst = 1'b0;
    bus.imemreq_val = 1'b0;
    bus.dmemreq_val = 1'b0;
    bus.memresp_val = 1'b0;
    @(negedge clk);
    check("rst_err", err, 0);
    check("rst_count", dut.count_q, 0);
    step();

    // Single imem read, response two cycles later
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h200;
    @(negedge clk);
    check("single_memreq_val", bus.memreq_val, 1);
    check("single_addr", bus.memreq_addr, 32'h200);
    check("single_type", bus.memreq_type, 0);
    check("single_wdata", bus.memreq_wdata, 0);
    check("single_imem_rdy", bus.imemreq_rdy, 1);
    check("single_dmem_rdy", bus.dmemreq_rdy, 0);
    step();
    bus.imemreq_val = 1'b0;
    step();
    mresp(1'b0, 32'h00000013, 1'b1);
    @(negedge clk);
    check("single_dmemresp_low", bus.dmemresp_val, 0);
    step();
    bus.memresp_val = 1'b0;
    check("single_count0", dut.count_q, 0);

    // Starvation: both valid every cycle, memory answers one cycle later
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h1000;
    bus.dmemreq_val  = 1'b1;
    bus.dmemreq_type = 1'b0;
    bus.dmemreq_addr = 32'h2000;
    prev_owner = 1'b0;
    for (int k = 0; k < 15; k++) begin
      exp_i = ((k % 5) == 4);
      if (k > 0) mresp(prev_owner, 32'h100 + k - 1, 1'b1);
      @(negedge clk);
      check("starve_imem_rdy", bus.imemreq_rdy, exp_i);
      check("starve_dmem_rdy", bus.dmemreq_rdy, !exp_i);
      check("starve_addr", bus.memreq_addr, exp_i ? 32'h1000 : 32'h2000);
      prev_owner = !exp_i;
      step();
    end
    bus.imemreq_val = 1'b0;
    bus.dmemreq_val = 1'b0;
    mresp(prev_owner, 32'h100 + 14, 1'b1);
    @(negedge clk);
    step();
    bus.memresp_val = 1'b0;
    check("starve_count0", dut.count_q, 0);

    // Depth limit and no same-cycle slot reuse
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h400;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("depth_fill_rdy", bus.imemreq_rdy, 1);
      step();
    end
    bus.dmemreq_val  = 1'b1;
    bus.dmemreq_addr = 32'h500;
    @(negedge clk);
    check("depth_full_memreq_val", bus.memreq_val, 0);
    check("depth_full_imem_rdy", bus.imemreq_rdy, 0);
    check("depth_full_dmem_rdy", bus.dmemreq_rdy, 0);
    step();
    mresp(1'b0, 32'h11, 1'b1);
    @(negedge clk);
    check("depth_pop_no_bypass", bus.memreq_val, 0);
    step();
    bus.memresp_val = 1'b0;
    @(negedge clk);
    check("depth_next_memreq_val", bus.memreq_val, 1);
    check("depth_next_dmem_rdy", bus.dmemreq_rdy, 1);
    check("depth_next_imem_rdy", bus.imemreq_rdy, 0);
    step();
    bus.imemreq_val = 1'b0;
    bus.dmemreq_val = 1'b0;
    mresp(1'b0, 32'h12, 1'b1);
    @(negedge clk);
    step();
    mresp(1'b1, 32'h22, 1'b1);
    @(negedge clk);
    step();
    bus.memresp_val = 1'b0;
    check("depth_count0", dut.count_q, 0);

    // Interleaved imem read and dmem write
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h300;
    @(negedge clk);
    check("inter_imem_rdy", bus.imemreq_rdy, 1);
    step();
    bus.imemreq_val   = 1'b0;
    bus.dmemreq_val   = 1'b1;
    bus.dmemreq_type  = 1'b1;
    bus.dmemreq_addr  = 32'h100;
    bus.dmemreq_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("inter_type", bus.memreq_type, 1);
    check("inter_addr", bus.memreq_addr, 32'h100);
    check("inter_wdata", bus.memreq_wdata, 32'hDEADBEEF);
    check("inter_dmem_rdy", bus.dmemreq_rdy, 1);
    step();
    bus.dmemreq_val  = 1'b0;
    bus.dmemreq_type = 1'b0;
    mresp(1'b0, 32'hAAAA0000, 1'b1);
    @(negedge clk);
    step();
    mresp(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    step();
    bus.memresp_val = 1'b0;
    @(negedge clk);
    check("inter_dmem_pulse_once", bus.dmemresp_val, 0);
    check("inter_imemresp_low", bus.imemresp_val, 0);
    step();

    // Stray response sets sticky err
    bus.memresp_val  = 1'b1;
    bus.memresp_data = 32'h55;
    @(negedge clk);
    check("stray_imemresp", bus.imemresp_val, 0);
    check("stray_dmemresp", bus.dmemresp_val, 0);
    step();
    bus.memresp_val = 1'b0;
    check("err_set", err, 1);
    step();
    step();
    check("err_sticky", err, 1);
    rst = 1'b1;
    bus.memresp_val = 1'b1;
    step();
    step();
    check("err_cleared_in_rst", err, 0);
    rst = 1'b0;
    bus.memresp_val = 1'b0;
    @(negedge clk);
    check("err_after_rst", err, 0);
    step();

    // Reset with two requests outstanding
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h600;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("midrst_fill_rdy", bus.imemreq_rdy, 1);
      step();
    end
    rst = 1'b1;
    bus.dmemreq_val = 1'b1;
    bus.memresp_val = 1'b1;
    @(negedge clk);
    check("midrst_memreq_val", bus.memreq_val, 0);
    check("midrst_imem_rdy", bus.imemreq_rdy, 0);
    check("midrst_dmem_rdy", bus.dmemreq_rdy, 0);
    check("midrst_imemresp", bus.imemresp_val, 0);
    check("midrst_dmemresp", bus.dmemresp_val, 0);
    step();
    check("midrst_count0", dut.count_q, 0);
    rst = 1'b0;
    bus.dmemreq_val  = 1'b0;
    bus.memresp_val  = 1'b0;
    bus.imemreq_addr = 32'h700;
    @(negedge clk);
    check("postrst_memreq_val", bus.memreq_val, 1);
    check("postrst_addr", bus.memreq_addr, 32'h700);
    check("postrst_imem_rdy", bus.imemreq_rdy, 1);
    step();
    bus.imemreq_val = 1'b0;
    mresp(1'b0, 32'h77, 1'b1);
    @(negedge clk);
    step();
    bus.memresp_val = 1'b0;
    check("postrst_count0", dut.count_q, 0);
    check("postrst_err", err, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
